// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: entry record, FSM state encoding,
// instruction size and a NOP word for debug fill.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // ADDI x0, x0, 0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous prefetch FIFO of fetch entries; flush wins over push/pop.
// Head reads as zero while empty so the decode-facing outputs are clean.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload storage carries no reset; validity lives entirely in cnt_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32E fetch stage: PC register, ROM addressing, prefetch queue and redirect.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the FAULT state and if_fault port.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        if_fault
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         q_full, q_empty, pop, push, advance;
  fetch_entry_t head, wentry;

  assign pop      = if_valid && if_ready;
  assign push     = (state_q == RUN) && !redirect_valid;
  assign advance  = push && (!q_full || pop);
  assign rom_addr = {pc_q[31:2], 2'b00};
  assign wentry   = '{pc: rom_addr, instr: rom_data};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head)
  );

  assign if_valid = !q_empty;
  assign if_pc    = head.pc;
  assign if_instr = head.instr;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign if_fault = (state_q == FAULT);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      // Keep the misaligned target in pc so the trap handler can see it.
      state_q <= (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
      pc_q    <= redirect_pc;
`else
      state_q <= RUN;
      pc_q    <= {redirect_pc[31:2], 2'b00};
`endif
    end else if (advance) begin
      pc_q <= pc_q + 32'(INSTR_BYTES);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed table, misalignment sequence,
// randomized run against a queue-based reference model, and async reset.
module tb_instruction_fetch;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_addr, rom_data, redirect_pc, if_instr, if_pc;
  logic        redirect_valid, if_valid, if_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        if_fault;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign rom_data = rom_word(rom_addr);

  instruction_fetch #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .if_fault       (if_fault)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  vec_t tbl[$];

  logic [31:0] m_pc;
  logic [31:0] mq[$];

  initial begin
    // Outputs expected before each cycle's edge, then inputs applied for it.
    tbl.push_back(mk(0, 0, 1, 0, 0,            32'h0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h0,        32'h4));
    tbl.push_back(mk(0, 0, 1, 1, 32'h4,        32'h8));
    tbl.push_back(mk(0, 0, 0, 1, 32'h8,        32'hC));
    tbl.push_back(mk(0, 0, 0, 1, 32'h8,        32'h10));
    tbl.push_back(mk(0, 0, 0, 1, 32'h8,        32'h10));
    tbl.push_back(mk(0, 0, 0, 1, 32'h8,        32'h10));
    tbl.push_back(mk(0, 0, 0, 1, 32'h8,        32'h10));
    tbl.push_back(mk(0, 0, 1, 1, 32'h8,        32'h10));
    tbl.push_back(mk(0, 0, 1, 1, 32'hC,        32'h14));
    tbl.push_back(mk(0, 0, 0, 1, 32'h10,       32'h18));
    tbl.push_back(mk(1, 32'h70, 0, 1, 32'h10,  32'h18));
    tbl.push_back(mk(0, 0, 1, 0, 0,            32'h70));
    tbl.push_back(mk(1, 32'h7C, 1, 1, 32'h70,  32'h74));
    tbl.push_back(mk(0, 0, 1, 0, 0,            32'h7C));
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 1, 1, 32'h7C, 32'h80));
    tbl.push_back(mk(0, 0, 1, 0, 0,            32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0));

    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'b0, if_valid}, 32'h0);
    check("reset_instr", if_instr, 32'h0);
    check("reset_pc", if_pc, 32'h0);
    check("reset_rom_addr", rom_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("reset_fault", {31'b0, if_fault}, 32'h0);
`endif
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("tbl%0d_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].ev});
      check($sformatf("tbl%0d_rom_addr", i), rom_addr, tbl[i].eaddr);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_pc", i), if_pc, tbl[i].epc);
        check($sformatf("tbl%0d_instr", i), if_instr, rom_word(tbl[i].epc));
      end
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      if_ready       = tbl[i].rdy;
      @(negedge clk);
    end

    // Misaligned redirect while the queue holds pc 0.
    check("mis_pre_pc", if_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h42; if_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mis_fault%0d", k), {31'b0, if_fault}, 32'h1);
      check($sformatf("mis_valid%0d", k), {31'b0, if_valid}, 32'h0);
      @(negedge clk);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h46;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("mis_refault", {31'b0, if_fault}, 32'h1);
    check("mis_refault_valid", {31'b0, if_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("mis_clear_fault", {31'b0, if_fault}, 32'h0);
`endif
    check("mis_valid_gap", {31'b0, if_valid}, 32'h0);
    check("mis_rom_addr", rom_addr, 32'h40);
    @(negedge clk);
    check("mis_valid_after", {31'b0, if_valid}, 32'h1);
    check("mis_pc_after", if_pc, 32'h40);
    check("mis_instr_after", if_instr, rom_word(32'h40));

    // Randomized run against a queue model of the fetch rules.
    reset = 1'b0; if_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_pc = 32'h0;
    mq.delete();
    for (int c = 0; c < 3000; c++) begin
      logic        rdy, redir, popd;
      logic [31:0] rpc;
      check("rnd_valid", {31'b0, if_valid}, {31'b0, mq.size() > 0});
      check("rnd_rom_addr", rom_addr, m_pc);
      if (mq.size() > 0) begin
        check("rnd_pc", if_pc, mq[0]);
        check("rnd_instr", if_instr, rom_word(mq[0]));
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rnd_fault", {31'b0, if_fault}, 32'h0);
`endif
      rdy   = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      redirect_valid = redir; redirect_pc = rpc; if_ready = rdy;
      popd = rdy && (mq.size() > 0);
      if (redir) begin
        mq.delete();
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        if (mq.size() < DEPTH || popd) begin
          if (popd) void'(mq.pop_front());
          mq.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end else if (popd) begin
          void'(mq.pop_front());
        end
      end
      @(negedge clk);
    end

    // Asynchronous reset mid-stream must clear outputs immediately.
    redirect_valid = 1'b0; if_ready = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_valid", {31'b0, if_valid}, 32'h0);
    check("async_pc", if_pc, 32'h0);
    check("async_instr", if_instr, 32'h0);
    check("async_rom_addr", rom_addr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    if_ready = 1'b1;
    @(negedge clk);
    check("post_reset_pc", if_pc, 32'h0);
    check("post_reset_valid", {31'b0, if_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
